// File: rtl/riscv_ifetch_pkg.sv
// Shared widths, NOP constant and fetch FSM encoding for the instruction-fetch responder.
// Imported by the bus interface, the fetch block and its bench.
package riscv_ifetch_pkg;

   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;

   typedef logic [InstAddrBus-1:0] addr_t;
   typedef logic [InstBus-1:0]     inst_t;

   localparam inst_t NOP_INST = 32'h0000_0013;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/riscv_ifetch_if.sv
// Instruction-memory request/acknowledge bus; master = fetch unit, slave = memory.
// One request held stable until the single-cycle acknowledge that carries the word.
interface riscv_ifetch_if;
   import riscv_ifetch_pkg::*;

   logic  mem_req_o;
   addr_t mem_addr_o;
   logic  mem_ack_i;
   inst_t mem_rdata_i;

   modport master (output mem_req_o, mem_addr_o, input  mem_ack_i, mem_rdata_i);
   modport slave  (input  mem_req_o, mem_addr_o, output mem_ack_i, mem_rdata_i);

endinterface

// File: rtl/riscv_ifetch.sv
// Instruction fetch: one bus transaction per PC, 2 cycles/instr plus bus wait states; stall_i holds IDLE,
// stall_req_o is high during WAIT, flushes drop in-flight data. IMEM_ALIGN_CHK_EN enables the misaligned-PC trap.
module riscv_ifetch
   import riscv_ifetch_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  addr_t                 pc_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   output logic                  stall_req_o,
   riscv_ifetch_if.master        mem,
   output inst_t                 inst_o,
   output addr_t                 inst_pc_o,
   output logic                  inst_valid_o,
   output logic                  inst_misalign_o
);

`ifdef IMEM_ALIGN_CHK_EN
   localparam bit AlignChk = 1'b1;
`else
   localparam bit AlignChk = 1'b0;
`endif

   fetch_state_e state_q;
   logic         drop_q;
   logic         mem_req_q;
   addr_t        mem_addr_q;
   inst_t        inst_q;
   addr_t        inst_pc_q;
   logic         inst_valid_q;
   logic         misalign_q;
   logic         pc_misaligned;

   // Without the alignment check this is constant 0, so misalign_q never sets.
   assign pc_misaligned = AlignChk && (pc_i[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         drop_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         inst_q       <= NOP_INST;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (flush_i) begin
                  inst_valid_q <= 1'b0;
                  misalign_q   <= 1'b0;
               end else if (!stall_i) begin
                  inst_valid_q <= 1'b0;
                  if (pc_misaligned) begin
                     misalign_q <= 1'b1;
                     inst_pc_q  <= pc_i;
                  end else begin
                     misalign_q <= 1'b0;
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= pc_i;
                     state_q    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // The request is never withdrawn; a flush only marks the word as stale.
               if (mem.mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  drop_q    <= 1'b0;
                  state_q   <= S_IDLE;
                  if (drop_q || flush_i) begin
                     inst_valid_q <= 1'b0;
                  end else begin
                     inst_q       <= mem.mem_rdata_i;
                     inst_pc_q    <= mem_addr_q;
                     inst_valid_q <= 1'b1;
                  end
               end else if (flush_i) begin
                  drop_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stall_req_o     = (state_q == S_WAIT);
   assign mem.mem_req_o   = mem_req_q;
   assign mem.mem_addr_o  = mem_addr_q;
   assign inst_o          = inst_q;
   assign inst_pc_o       = inst_pc_q;
   assign inst_valid_o    = inst_valid_q;
   assign inst_misalign_o = misalign_q;

endmodule

// File: tb/tb_riscv_ifetch.sv
// Scoreboard bench for riscv_ifetch: directed timing cases then randomized stall/flush/wait traffic.
module tb_riscv_ifetch;

`ifdef IMEM_ALIGN_CHK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   localparam logic [31:0] XKEY = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_i = 32'h0;
   logic        stall_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        stall_req_o;
   logic [31:0] inst_o, inst_pc_o;
   logic        inst_valid_o, inst_misalign_o;

   always #5 clk = ~clk;

   riscv_ifetch_if bus();

   logic        resp_ack = 1'b0;
   logic        man_ack = 1'b0;
   logic [31:0] resp_rdata = 32'h0;
   assign bus.mem_ack_i   = resp_ack | man_ack;
   assign bus.mem_rdata_i = resp_rdata;

   riscv_ifetch dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pc_i            (pc_i),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .stall_req_o     (stall_req_o),
      .mem             (bus.master),
      .inst_o          (inst_o),
      .inst_pc_o       (inst_pc_o),
      .inst_valid_o    (inst_valid_o),
      .inst_misalign_o (inst_misalign_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory slave: acks after wait_n cycles, data is a fixed function of the address.
   int fixed_wait = 0;
   int cnt = 0;
   int wait_n = 0;
   always @(posedge clk) begin
      #1;
      if (rst_n && bus.mem_req_o) begin
         if (cnt == 0) wait_n = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
         resp_ack   = (cnt == wait_n);
         resp_rdata = resp_ack ? (bus.mem_addr_o ^ XKEY) : $urandom;
         cnt++;
      end else begin
         resp_ack = 1'b0;
         cnt      = 0;
      end
   end

   // Transaction-level reference: one outstanding fetch, delivered unless a flush hit it.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;
   exp_t        q[$];
   exp_t        e;
   logic        busy = 1'b0, dropped = 1'b0, exp_valid = 1'b0, exp_mis = 1'b0, issued_now = 1'b0;
   logic [31:0] cur_pc = 32'h0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy = 1'b0; dropped = 1'b0; exp_valid = 1'b0; exp_mis = 1'b0; issued_now = 1'b0;
         q.delete();
      end else begin
         issued_now = 1'b0;
         if (!busy) begin
            if (flush_i) begin
               exp_valid = 1'b0;
               exp_mis   = 1'b0;
            end else if (!stall_i) begin
               exp_valid = 1'b0;
               if (ALIGN && pc_i[1:0] != 2'b00) begin
                  exp_mis = 1'b1;
               end else begin
                  exp_mis    = 1'b0;
                  busy       = 1'b1;
                  dropped    = 1'b0;
                  cur_pc     = pc_i;
                  issued_now = 1'b1;
               end
            end
         end else if (bus.mem_ack_i) begin
            busy = 1'b0;
            if (dropped || flush_i) begin
               exp_valid = 1'b0;
            end else begin
               q.push_back('{cur_pc, cur_pc ^ XKEY});
               exp_valid = 1'b1;
            end
            dropped = 1'b0;
         end else if (flush_i) begin
            dropped = 1'b1;
         end
      end
   end

   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         chkb("stall_req", stall_req_o, busy);
         chkb("mem_req", bus.mem_req_o, busy);
         if (busy) chk("mem_addr", bus.mem_addr_o, cur_pc);
         chkb("inst_valid", inst_valid_o, exp_valid);
         chkb("misalign", inst_misalign_o, exp_mis);
         if (inst_valid_o && !prev_valid) begin
            if (q.size() == 0) begin
               chkb("spurious_valid", inst_valid_o, 1'b0);
            end else begin
               e = q.pop_front();
               chk("sb_inst_pc", inst_pc_o, e.pc);
               chk("sb_inst", inst_o, e.inst);
            end
         end
      end
      prev_valid = rst_n ? inst_valid_o : 1'b0;
   end

   logic        auto_pc = 1'b0;
   logic [31:0] tgt = 32'h0;

   task automatic step();
      logic fl;
      fl = flush_i;
      @(posedge clk);
      #1;
      if (auto_pc) begin
         if (fl) pc_i = tgt;
         else if (issued_now) pc_i = pc_i + 32'd4;
      end
   endtask

   task automatic chk_reset(input string tag);
      chkb({tag, "_req"}, bus.mem_req_o, 1'b0);
      chk({tag, "_addr"}, bus.mem_addr_o, 32'h0);
      chk({tag, "_inst"}, inst_o, 32'h0000_0013);
      chk({tag, "_inst_pc"}, inst_pc_o, 32'h0);
      chkb({tag, "_valid"}, inst_valid_o, 1'b0);
      chkb({tag, "_mis"}, inst_misalign_o, 1'b0);
      chkb({tag, "_stall_req"}, stall_req_o, 1'b0);
   endtask

   initial begin
      int sc, vc;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("rst");
      rst_n = 1'b1;
      step();
      chk_reset("rst_hold");

      // Zero-wait bus: three back-to-back fetches
      fixed_wait = 0; pc_i = 32'h0; auto_pc = 1'b1; stall_i = 1'b0;
      sc = 0; vc = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         sc += int'(stall_req_o);
         vc += int'(inst_valid_o);
      end
      stall_i = 1'b1; auto_pc = 1'b0;
      chk("zw_stall_cycles", 32'(sc), 32'd3);
      chk("zw_valid_cycles", 32'(vc), 32'd3);
      chk("zw_last_pc", inst_pc_o, 32'h8);

      // Three wait states
      fixed_wait = 3; pc_i = 32'h10; stall_i = 1'b0;
      step();
      stall_i = 1'b1;
      sc = int'(stall_req_o);
      for (int i = 0; i < 5; i++) begin
         step();
         sc += int'(stall_req_o);
      end
      chk("dly_stall_cycles", 32'(sc), 32'd4);
      chkb("dly_valid_held", inst_valid_o, 1'b1);
      chk("dly_inst_pc", inst_pc_o, 32'h10);
      chk("dly_inst", inst_o, 32'h10 ^ XKEY);

      // Flush in 2nd WAIT cycle, ack in 4th
      pc_i = 32'h40; stall_i = 1'b0;
      step();
      step();
      flush_i = 1'b1; pc_i = 32'h100;
      step();
      flush_i = 1'b0;
      step();
      step();
      chkb("fl_no_valid", inst_valid_o, 1'b0);
      chkb("fl_req_low", bus.mem_req_o, 1'b0);
      step();
      chkb("fl_target_req", bus.mem_req_o, 1'b1);
      chk("fl_target_addr", bus.mem_addr_o, 32'h100);
      stall_i = 1'b1;
      repeat (5) step();

      // Flush coincident with ack
      fixed_wait = 1; pc_i = 32'h200; stall_i = 1'b0;
      step();
      stall_i = 1'b1;
      step();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chkb("fa_valid", inst_valid_o, 1'b0);
      chkb("fa_idle", stall_req_o, 1'b0);

      // Unaligned PC
      fixed_wait = 0; pc_i = 32'h102; stall_i = 1'b0;
      step();
      stall_i = 1'b1;
      if (ALIGN) begin
         chkb("mis_no_req", bus.mem_req_o, 1'b0);
         chkb("mis_flag", inst_misalign_o, 1'b1);
         chk("mis_pc", inst_pc_o, 32'h102);
         pc_i = 32'h104; stall_i = 1'b0;
         step();
         stall_i = 1'b1;
         chkb("mis_clear", inst_misalign_o, 1'b0);
      end else begin
         chk("unal_addr", bus.mem_addr_o, 32'h102);
         step();
         chk("unal_inst_pc", inst_pc_o, 32'h102);
         pc_i = 32'h104; stall_i = 1'b0;
         step();
         stall_i = 1'b1;
      end
      chkb("al_req", bus.mem_req_o, 1'b1);
      chk("al_addr", bus.mem_addr_o, 32'h104);
      repeat (3) step();

      // Reset mid-WAIT, then a stray ack after release
      fixed_wait = 5; pc_i = 32'h300; stall_i = 1'b0;
      step();
      stall_i = 1'b1;
      step();
      #1 rst_n = 1'b0;
      #1 chk_reset("arst");
      step();
      rst_n = 1'b1;
      fixed_wait = 0;
      man_ack = 1'b1;
      step();
      man_ack = 1'b0;
      step();
      chk_reset("arst_ack");
      stall_i = 1'b0;
      step();
      stall_i = 1'b1;
      chkb("restart_req", bus.mem_req_o, 1'b1);
      chk("restart_addr", bus.mem_addr_o, 32'h300);
      repeat (3) step();

      // Randomized traffic
      fixed_wait = -1; auto_pc = 1'b1; pc_i = 32'h1000;
      for (int i = 0; i < 600; i++) begin
         stall_i = ($urandom_range(0, 4) == 0);
         flush_i = ($urandom_range(0, 7) == 0);
         tgt     = $urandom & 32'h0000_FFFC;
         step();
      end
      flush_i = 1'b0; stall_i = 1'b1; auto_pc = 1'b0;
      repeat (8) step();
      chk("sb_drained", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
